// File: rtl/prog_clock_divider_if.sv
// Control and status bundle for the programmable clock divider.
// The divider sits on the slave side; the consumer of the divided clock drives it through master.
interface prog_clock_divider_if #(
    parameter int WIDTH = 28
);
    logic             enable;
    logic             load;
    logic [WIDTH-1:0] divisor_in;
    logic [WIDTH-1:0] high_in;
    logic             clock_out;
    logic             tick;
    logic             pending;
    logic             load_err;
    logic [WIDTH-1:0] phase;

    modport master (
        output enable, load, divisor_in, high_in,
        input  clock_out, tick, pending, load_err, phase
    );

    modport slave (
        input  enable, load, divisor_in, high_in,
        output clock_out, tick, pending, load_err, phase
    );
endinterface

// File: rtl/prog_clock_divider.sv
// Runtime-programmable clock divider with duty control, freeze, period tick
// and shadowed divisor reload that only takes effect at period boundaries.
module prog_clock_divider #(
    parameter int WIDTH           = 28,
    parameter int DEFAULT_DIVISOR = 25000,
    parameter int DEFAULT_HIGH    = 12500
) (
    input  logic                 clock_in,
    input  logic                 reset,
    prog_clock_divider_if.slave  bus
);
    localparam logic [WIDTH-1:0] DEF_DIV  = WIDTH'(DEFAULT_DIVISOR);
    localparam logic [WIDTH-1:0] DEF_HIGH = WIDTH'(DEFAULT_HIGH);

    function automatic logic [WIDTH-1:0] clamp_div(input logic [WIDTH-1:0] d);
        return (d < WIDTH'(2)) ? WIDTH'(2) : d;
    endfunction

    // High time must leave at least one low cycle, so it is bounded by the clamped divisor.
    function automatic logic [WIDTH-1:0] clamp_high(input logic [WIDTH-1:0] h,
                                                    input logic [WIDTH-1:0] d);
        logic [WIDTH-1:0] t;
        t = (h == '0) ? WIDTH'(1) : h;
        if (t > d - WIDTH'(1))
            t = d - WIDTH'(1);
        return t;
    endfunction

    logic [WIDTH-1:0] r_div_act, r_high_act, r_div_sh, r_high_sh, r_cnt;
    logic             r_pending, r_clk, r_tick, r_err;

    logic [WIDTH-1:0] w_div_cl, w_high_cl, w_cnt_next, w_high_eff;
    logic             w_clamped, w_wrap, w_swap;

    always_comb begin
        w_div_cl   = clamp_div(bus.divisor_in);
        w_high_cl  = clamp_high(bus.high_in, w_div_cl);
        w_clamped  = (w_div_cl != bus.divisor_in) || (w_high_cl != bus.high_in);
        w_wrap     = (r_cnt == r_div_act - WIDTH'(1));
        w_cnt_next = w_wrap ? '0 : r_cnt + WIDTH'(1);
        w_swap     = w_wrap && r_pending;
        w_high_eff = w_swap ? r_high_sh : r_high_act;
    end

    always_ff @(posedge clock_in) begin
        if (reset) begin
            r_div_act  <= DEF_DIV;
            r_high_act <= DEF_HIGH;
            r_div_sh   <= DEF_DIV;
            r_high_sh  <= DEF_HIGH;
            r_cnt      <= DEF_DIV - WIDTH'(1);
            r_pending  <= 1'b0;
            r_clk      <= 1'b0;
            r_tick     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_err <= bus.load && w_clamped;
            if (bus.enable) begin
                r_cnt  <= w_cnt_next;
                r_clk  <= (w_cnt_next < w_high_eff);
                r_tick <= (w_cnt_next == '0);
                if (w_swap) begin
                    r_div_act  <= r_div_sh;
                    r_high_act <= r_high_sh;
                    r_pending  <= 1'b0;
                end
                // A load on the wrap edge lands in the shadow after the swap has consumed the old one.
                if (bus.load) begin
                    r_div_sh  <= w_div_cl;
                    r_high_sh <= w_high_cl;
                    r_pending <= 1'b1;
                end
            end else begin
                r_tick <= 1'b0;
                if (bus.load) begin
                    r_div_act  <= w_div_cl;
                    r_high_act <= w_high_cl;
                    r_div_sh   <= w_div_cl;
                    r_high_sh  <= w_high_cl;
                    r_cnt      <= w_div_cl - WIDTH'(1);
                    r_clk      <= 1'b0;
                    r_pending  <= 1'b0;
                end
            end
        end
    end

    assign bus.clock_out = r_clk;
    assign bus.tick      = r_tick;
    assign bus.pending   = r_pending;
    assign bus.load_err  = r_err;
    assign bus.phase     = r_cnt;
endmodule

// File: tb/tb_prog_clock_divider.sv
// Scoreboard bench for prog_clock_divider: a behavioural model pushes the expected
// outputs for every driven cycle, and they are popped and compared after the edge.
module tb_prog_clock_divider;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    prog_clock_divider_if #(.WIDTH(8)) bus ();

    prog_clock_divider #(
        .WIDTH(8),
        .DEFAULT_DIVISOR(10),
        .DEFAULT_HIGH(5)
    ) dut (
        .clock_in(clk),
        .reset(rst),
        .bus(bus.slave)
    );

    typedef struct packed {
        logic       clk;
        logic       tick;
        logic       pend;
        logic       err;
        logic [7:0] phase;
    } exp_t;

    exp_t exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;
    int n_high   = 0;
    int n_tick   = 0;

    int m_div, m_high, m_sdiv, m_shigh, m_phase;
    bit m_pend, m_clk, m_tick, m_err;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    endtask

    task automatic model_step(input bit r, input bit en, input bit ld, input int d, input int h);
        int cd, ch;
        bit nerr;
        cd = (d < 2) ? 2 : d;
        ch = (h < 1) ? 1 : h;
        if (ch > cd - 1) ch = cd - 1;
        nerr = ld && ((cd != d) || (ch != h));
        if (r) begin
            m_div = 10; m_high = 5; m_sdiv = 10; m_shigh = 5;
            m_phase = 9; m_pend = 0; m_clk = 0; m_tick = 0; m_err = 0;
        end else begin
            if (en) begin
                if (m_phase == m_div - 1) begin
                    m_phase = 0;
                    if (m_pend) begin
                        m_div = m_sdiv; m_high = m_shigh; m_pend = 0;
                    end
                end else begin
                    m_phase = m_phase + 1;
                end
                if (ld) begin
                    m_sdiv = cd; m_shigh = ch; m_pend = 1;
                end
                m_clk  = (m_phase < m_high);
                m_tick = (m_phase == 0);
            end else begin
                m_tick = 0;
                if (ld) begin
                    m_div = cd; m_high = ch; m_sdiv = cd; m_shigh = ch;
                    m_phase = cd - 1; m_clk = 0; m_pend = 0;
                end
            end
            m_err = nerr;
        end
    endtask

    task automatic cycle(input bit r, input bit en, input bit ld, input int d, input int h);
        exp_t e;
        rst            = r;
        bus.enable     = en;
        bus.load       = ld;
        bus.divisor_in = d[7:0];
        bus.high_in    = h[7:0];
        model_step(r, en, ld, d, h);
        exp_q.push_back(exp_t'{m_clk, m_tick, m_pend, m_err, m_phase[7:0]});
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 1, 0);
        end else begin
            e = exp_q.pop_front();
            chk("clock_out", int'(bus.clock_out), int'(e.clk));
            chk("tick",      int'(bus.tick),      int'(e.tick));
            chk("pending",   int'(bus.pending),   int'(e.pend));
            chk("load_err",  int'(bus.load_err),  int'(e.err));
            chk("phase",     int'(bus.phase),     int'(e.phase));
        end
        if (bus.clock_out) n_high++;
        if (bus.tick) n_tick++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle(0, 1, 0, 0, 0);
    endtask

    task automatic run_to_phase(input int p);
        int guard;
        guard = 0;
        while (m_phase != p && guard < 40) begin
            cycle(0, 1, 0, 0, 0);
            guard++;
        end
        if (m_phase != p) chk("run_to_phase_timeout", m_phase, p);
    endtask

    initial begin
        bus.enable = 0; bus.load = 0; bus.divisor_in = '0; bus.high_in = '0;

        // 1: defaults, 10-cycle period with 5 high
        for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 0);
        n_high = 0; n_tick = 0;
        run(20);
        chk("s1_high_cycles", n_high, 10);
        chk("s1_ticks", n_tick, 2);

        // 2: queued reload applied only at the wrap
        run_to_phase(3);
        cycle(0, 1, 1, 4, 1);
        run(16);

        // 3: clamped loads
        cycle(0, 1, 1, 1, 0);
        run(8);
        cycle(0, 1, 1, 6, 9);
        run(14);

        // 4: freeze mid-high and resume
        run_to_phase(2);
        for (int i = 0; i < 7; i++) cycle(0, 0, 0, 0, 0);
        run(7);

        // 5: immediate load while frozen
        cycle(0, 0, 1, 3, 2);
        chk("s5_phase", int'(bus.phase), 2);
        run(6);

        // 6: reset discards a pending configuration
        cycle(0, 0, 1, 10, 5);
        cycle(0, 1, 1, 4, 2);
        run_to_phase(6);
        chk("s6_pending_before_reset", int'(bus.pending), 1);
        cycle(1, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        n_high = 0; n_tick = 0;
        run(20);
        chk("s6_high_cycles", n_high, 10);
        chk("s6_ticks", n_tick, 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
